// File: rtl/regf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regf_pkg
//  Description : Shared definitions for the multi-read-port register file:
//                sequencer state encoding, parameter limits and the even
//                parity helper used by the optional parity store.
//  Revision    : 1.0 - initial release
// ============================================================================
package regf_pkg;

    // Parameter limits for the register file
    localparam int MAX_DEPTH = 256;
    localparam int MAX_RD    = 4;
    localparam int MAX_DW    = 256;

    // Clear-sequencer state encoding
    localparam logic [0:0] c_ST_INIT = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    // Even parity bit: makes the total number of ones (data + bit) even.
    // Narrower words are zero-extended by the caller, which leaves the
    // parity unchanged.
    function automatic logic even_parity(input logic [MAX_DW-1:0] d);
        return ^d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regf_rd_port.sv
`default_nettype none
// ============================================================================
//  Module      : regf_rd_port
//  Description : One read port of the register file: registered address with
//                stall hold, then combinational select between zero register,
//                out-of-range zero, write-stage bypass and bank word.
//                Optional macro REGF_PARITY_EN adds the parity check output.
//  Revision    : 1.0 - initial release
// ============================================================================
module regf_rd_port
    import regf_pkg::*;
#(
    parameter int DW       = 32,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(DEPTH),
    parameter int BW       = DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_init,
    input  logic          i_hold,
    input  logic [AW-1:0] i_addr,
    output logic [AW-1:0] o_addr_q,
    input  logic [BW-1:0] i_bank_word,
    input  logic          i_s_wren,
    input  logic [AW-1:0] i_s_addr,
    input  logic [DW-1:0] i_s_data,
    output logic [DW-1:0] o_data
`ifdef REGF_PARITY_EN
    ,
    output logic          o_perr
`endif
);

    logic [AW-1:0] r_addr;
    logic          w_in_range;
    logic          w_zero_hit;
    logic          w_bypass;

    // Address register; the stall hold is ignored while the bank is clearing
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= '0;
        end else if (i_init || !i_hold) begin
            r_addr <= i_addr;
        end
    end

    assign o_addr_q = r_addr;

    generate
        if (DEPTH == (1 << AW)) begin : g_full_range
            assign w_in_range = 1'b1;
        end else begin : g_part_range
            localparam logic [AW:0] c_DEPTH = (AW + 1)'(DEPTH);
            assign w_in_range = ({1'b0, r_addr} < c_DEPTH);
        end
    endgenerate

    assign w_zero_hit = (ZERO_REG != 0) && (r_addr == '0);
    assign w_bypass   = i_s_wren && (i_s_addr == r_addr);

    // Output select: zero reg and range beat bypass, bypass beats the bank
    always_comb begin
        o_data = '0;
        if (!i_init && w_in_range && !w_zero_hit) begin
            if (w_bypass) begin
                o_data = i_s_data;
            end else begin
                o_data = i_bank_word[DW-1:0];
            end
        end
    end

`ifdef REGF_PARITY_EN
    // Parity is only meaningful when the word actually came from the bank
    assign o_perr = !i_init && w_in_range && !w_zero_hit && !w_bypass &&
                    (even_parity(MAX_DW'(i_bank_word[DW-1:0])) != i_bank_word[DW]);
`endif

endmodule
`default_nettype wire

// File: rtl/regf_mp.sv
`default_nettype none
// ============================================================================
//  Module      : regf_mp
//  Description : Parametrised single-write, multi-read register file with a
//                clear sequencer after reset, a registered write stage with
//                per-port bypass, and an optional hard-wired zero entry.
//                Optional macro REGF_PARITY_EN stores an even parity bit per
//                entry and adds the rd_perr output.
//  Revision    : 1.0 - initial release
// ============================================================================
module regf_mp
    import regf_pkg::*;
#(
    parameter int DW       = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd_hold,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD*DW-1:0] rd_data,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [DW-1:0]        wr_data,
    output logic                 init_busy
`ifdef REGF_PARITY_EN
    ,
    output logic [NUM_RD-1:0]    rd_perr
`endif
);

`ifdef REGF_PARITY_EN
    localparam int c_BW = DW + 1;
`else
    localparam int c_BW = DW;
`endif
    localparam logic [AW-1:0] c_LAST = AW'(DEPTH - 1);

    logic [0:0]      r_state;
    logic [AW-1:0]   r_clr_ptr;
    logic            r_s_wren;
    logic [AW-1:0]   r_s_addr;
    logic [DW-1:0]   r_s_data;
    logic [c_BW-1:0] w_s_word;
    logic [c_BW-1:0] r_bank [DEPTH];
    logic            w_init;
    logic            w_wr_in_range;
    logic            w_wr_ok;

    assign w_init    = (r_state == c_ST_INIT);
    assign init_busy = w_init;

    // Clear sequencer: one entry per cycle, then hand over to normal run
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_INIT;
            r_clr_ptr <= '0;
        end else if (r_state == c_ST_INIT) begin
            r_clr_ptr <= r_clr_ptr + AW'(1);
            if (r_clr_ptr == c_LAST) begin
                r_state <= c_ST_RUN;
            end
        end
    end

    generate
        if (DEPTH == (1 << AW)) begin : g_wr_full_range
            assign w_wr_in_range = 1'b1;
        end else begin : g_wr_part_range
            localparam logic [AW:0] c_DEPTH = (AW + 1)'(DEPTH);
            assign w_wr_in_range = ({1'b0, wr_addr} < c_DEPTH);
        end
    endgenerate

    // Writes that can never land are dropped before the stage
    assign w_wr_ok = wr_en && !w_init && w_wr_in_range &&
                     !((ZERO_REG != 0) && (wr_addr == '0));

    // Write stage, independent of the read-side stall
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_wren <= 1'b0;
            r_s_addr <= '0;
            r_s_data <= '0;
        end else begin
            r_s_wren <= w_wr_ok;
            r_s_addr <= wr_addr;
            r_s_data <= wr_data;
        end
    end

`ifdef REGF_PARITY_EN
    logic r_s_par;

    // Parity is generated once, at the stage, and travels with the data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_par <= 1'b0;
        end else begin
            r_s_par <= even_parity(MAX_DW'(wr_data));
        end
    end

    assign w_s_word = {r_s_par, r_s_data};
`else
    assign w_s_word = r_s_data;
`endif

    // Bank update: clearing has priority; the staged write commits in run
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_init) begin
                r_bank[r_clr_ptr] <= '0;
            end else if (r_s_wren) begin
                r_bank[r_s_addr] <= w_s_word;
            end
        end
    end

    generate
        for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
            logic [AW-1:0]   w_addr_q;
            logic [c_BW-1:0] w_word;
            logic            w_idx_ok;

            if (DEPTH == (1 << AW)) begin : g_idx_full
                assign w_idx_ok = 1'b1;
            end else begin : g_idx_part
                localparam logic [AW:0] c_DEPTH = (AW + 1)'(DEPTH);
                assign w_idx_ok = ({1'b0, w_addr_q} < c_DEPTH);
            end

            assign w_word = w_idx_ok ? r_bank[w_addr_q] : '0;

            regf_rd_port #(
                .DW       (DW),
                .DEPTH    (DEPTH),
                .ZERO_REG (ZERO_REG),
                .AW       (AW),
                .BW       (c_BW)
            ) u_port (
                .clk         (clk),
                .rst         (rst),
                .i_init      (w_init),
                .i_hold      (rd_hold),
                .i_addr      (rd_addr[k*AW +: AW]),
                .o_addr_q    (w_addr_q),
                .i_bank_word (w_word),
                .i_s_wren    (r_s_wren),
                .i_s_addr    (r_s_addr),
                .i_s_data    (r_s_data),
                .o_data      (rd_data[k*DW +: DW])
`ifdef REGF_PARITY_EN
                ,
                .o_perr      (rd_perr[k])
`endif
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regf_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regf_mp
//  Description : Scoreboard bench for regf_mp. Two instances: A (DEPTH=32,
//                2 ports, zero register) and B (DEPTH=24, 3 ports, no zero
//                register). Stimulus pushes expected values with a due cycle;
//                a negedge monitor compares them against the outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regf_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;

    logic        a_hold = 1'b0;
    logic [9:0]  a_raddr = '0;
    logic [63:0] a_rdata;
    logic        a_wen = 1'b0;
    logic [4:0]  a_waddr = '0;
    logic [31:0] a_wdata = '0;
    logic        a_busy;
    logic [1:0]  a_perr;

    logic        b_hold = 1'b0;
    logic [14:0] b_raddr = '0;
    logic [95:0] b_rdata;
    logic        b_wen = 1'b0;
    logic [4:0]  b_waddr = '0;
    logic [31:0] b_wdata = '0;
    logic        b_busy;
    logic [2:0]  b_perr;

    regf_mp #(.DW(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(1)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .rd_hold   (a_hold),
        .rd_addr   (a_raddr),
        .rd_data   (a_rdata),
        .wr_en     (a_wen),
        .wr_addr   (a_waddr),
        .wr_data   (a_wdata),
        .init_busy (a_busy)
`ifdef REGF_PARITY_EN
        ,
        .rd_perr   (a_perr)
`endif
    );

    regf_mp #(.DW(32), .DEPTH(24), .NUM_RD(3), .ZERO_REG(0)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .rd_hold   (b_hold),
        .rd_addr   (b_raddr),
        .rd_data   (b_rdata),
        .wr_en     (b_wen),
        .wr_addr   (b_waddr),
        .wr_data   (b_wdata),
        .init_busy (b_busy)
`ifdef REGF_PARITY_EN
        ,
        .rd_perr   (b_perr)
`endif
    );

`ifndef REGF_PARITY_EN
    assign a_perr = '0;
    assign b_perr = '0;
`endif

    typedef struct {
        int            due;
        int            dut;
        int            kind;   // 0 = rd_data, 1 = init_busy, 2 = rd_perr
        int            port;
        logic [31:0]   val;
        logic [95:0]   name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_push(input int dut, input int kind, input int port,
                            input int lat, input logic [31:0] val,
                            input logic [95:0] name);
        exp_t e;
        e.due  = cyc + lat;
        e.dut  = dut;
        e.kind = kind;
        e.port = port;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] observe(input int dut, input int kind, input int port);
        logic [31:0] v;
        v = '0;
        case (kind)
            0: v = (dut == 0) ? a_rdata[port*32 +: 32] : b_rdata[port*32 +: 32];
            1: v = (dut == 0) ? 32'(a_busy) : 32'(b_busy);
            default: v = (dut == 0) ? 32'(a_perr[port]) : 32'(b_perr[port]);
        endcase
        return v;
    endfunction

    // Monitor: compare every expectation whose due cycle has arrived
    always @(negedge clk) begin
        logic [31:0] got;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due <= cyc) begin
                got = observe(sb[i].dut, sb[i].kind, sb[i].port);
                n_tests = n_tests + 1;
                if (sb[i].due < cyc || got !== sb[i].val) begin
                    n_fail = n_fail + 1;
                    $display("FAIL %0s: dut%0d kind%0d port%0d got %h expected %h (cycle %0d)",
                             sb[i].name, sb[i].dut, sb[i].kind, sb[i].port,
                             got, sb[i].val, cyc);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        // Reset, then a second reset part-way through the clear sequence
        tick();
        n_tests = n_tests + 1;
        if (a_busy !== 1'b1) begin
            n_fail = n_fail + 1;
            $display("FAIL rst_busy_direct_a: got %b expected 1", a_busy);
        end
        n_tests = n_tests + 1;
        if (b_busy !== 1'b1) begin
            n_fail = n_fail + 1;
            $display("FAIL rst_busy_direct_b: got %b expected 1", b_busy);
        end
        exp_push(0, 1, 0, 0, 32'd1, "rst_busy_a");
        exp_push(1, 1, 0, 0, 32'd1, "rst_busy_b");
        exp_push(0, 0, 0, 0, 32'd0, "rst_data_a");
        rst = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_push(0, 1, 0, 0, 32'd1, "init_busy_a");

        // Writes presented during the clear must vanish
        a_wen = 1'b1; a_waddr = 5'd5; a_wdata = 32'hFFFF_FFFF;
        b_wen = 1'b1; b_waddr = 5'd5; b_wdata = 32'hFFFF_FFFF;
        for (int k = 1; k <= 33; k++) begin
            tick();
            if (k == 2) begin
                a_wen = 1'b0;
                b_wen = 1'b0;
            end
            if (k == 23) exp_push(1, 1, 0, 0, 32'd1, "busy_end_b");
            if (k == 24) exp_push(1, 1, 0, 0, 32'd0, "busy_off_b");
            if (k == 31) exp_push(0, 1, 0, 0, 32'd1, "busy_end_a");
            if (k == 32) exp_push(0, 1, 0, 0, 32'd0, "busy_off_a");
        end

        // Every entry reads zero after the clear
        for (int i = 0; i < 32; i++) begin
            a_raddr = {5'(31 - i), 5'(i)};
            b_raddr = {5'(i), 5'(i), 5'(i)};
            exp_push(0, 0, 0, 1, 32'd0, "clear_a0");
            exp_push(0, 0, 1, 1, 32'd0, "clear_a1");
            for (int p = 0; p < 3; p++) exp_push(1, 0, p, 1, 32'd0, "clear_b");
            tick();
        end

        // Write then read: bypass next cycle, bank afterwards
        a_raddr = {5'd5, 5'd5};
        a_wen = 1'b1; a_waddr = 5'd5; a_wdata = 32'hDEAD_BEEF;
        exp_push(0, 0, 0, 1, 32'hDEAD_BEEF, "byp_a0");
        exp_push(0, 0, 1, 1, 32'hDEAD_BEEF, "byp_a1");
        exp_push(0, 0, 0, 3, 32'hDEAD_BEEF, "bank_a0");
        tick();
        a_wen = 1'b0;
        repeat (3) tick();

        // Entry 0: hard zero on A, ordinary register on B
        a_raddr[4:0] = 5'd0;
        a_wen = 1'b1; a_waddr = 5'd0; a_wdata = 32'h0000_1234;
        b_raddr[4:0] = 5'd0;
        b_wen = 1'b1; b_waddr = 5'd0; b_wdata = 32'h0000_1234;
        exp_push(0, 0, 0, 1, 32'd0, "zero_byp_a");
        exp_push(0, 0, 0, 3, 32'd0, "zero_bank_a");
        exp_push(1, 0, 0, 1, 32'h0000_1234, "r0_byp_b");
        exp_push(1, 0, 0, 3, 32'h0000_1234, "r0_bank_b");
        tick();
        a_wen = 1'b0;
        b_wen = 1'b0;
        repeat (3) tick();

        // Back-to-back writes to one entry: newest value wins
        a_raddr[9:5] = 5'd6;
        a_wen = 1'b1; a_waddr = 5'd6; a_wdata = 32'h0000_0001;
        exp_push(0, 0, 1, 1, 32'h0000_0001, "b2b_first");
        tick();
        a_wdata = 32'h0000_0002;
        exp_push(0, 0, 1, 1, 32'h0000_0002, "b2b_byp");
        exp_push(0, 0, 1, 3, 32'h0000_0002, "b2b_bank");
        tick();
        a_wen = 1'b0;
        repeat (3) tick();

        // Hold: address 7 stays registered and still sees the new write
        a_wen = 1'b1; a_waddr = 5'd9; a_wdata = 32'h0000_0099;
        tick();
        a_wen = 1'b0;
        a_raddr[4:0] = 5'd7;
        tick();
        a_hold = 1'b1;
        a_raddr[4:0] = 5'd9;
        a_wen = 1'b1; a_waddr = 5'd7; a_wdata = 32'hA5A5_A5A5;
        exp_push(0, 0, 0, 0, 32'd0, "hold_pre");
        exp_push(0, 0, 0, 1, 32'hA5A5_A5A5, "hold_byp");
        exp_push(0, 0, 0, 2, 32'hA5A5_A5A5, "hold_bank");
        tick();
        a_wen = 1'b0;
        tick();
        a_hold = 1'b0;
        exp_push(0, 0, 0, 1, 32'h0000_0099, "hold_rel");
        repeat (2) tick();

        // Three ports hit the same staged write together
        b_raddr = {5'd10, 5'd10, 5'd10};
        b_wen = 1'b1; b_waddr = 5'd10; b_wdata = 32'hCAFE_F00D;
        for (int p = 0; p < 3; p++) exp_push(1, 0, p, 1, 32'hCAFE_F00D, "multi_byp");
        exp_push(1, 0, 1, 3, 32'hCAFE_F00D, "multi_bank");
        tick();
        b_wen = 1'b0;
        repeat (3) tick();

        // Out-of-range address on the 24-entry file
        b_raddr = {5'd30, 5'd30, 5'd30};
        b_wen = 1'b1; b_waddr = 5'd30; b_wdata = 32'h0000_0055;
        for (int p = 0; p < 3; p++) exp_push(1, 0, p, 1, 32'd0, "oor_byp");
        exp_push(1, 0, 0, 3, 32'd0, "oor_bank");
        tick();
        b_wen = 1'b0;
        repeat (3) tick();

        // Highest valid entry of the 24-entry file
        b_raddr[14:10] = 5'd23;
        b_wen = 1'b1; b_waddr = 5'd23; b_wdata = 32'h0000_2323;
        exp_push(1, 0, 2, 1, 32'h0000_2323, "last_byp");
        exp_push(1, 0, 2, 3, 32'h0000_2323, "last_bank");
        tick();
        b_wen = 1'b0;
        repeat (3) tick();

`ifdef REGF_PARITY_EN
        // Corrupt one stored bit of entry 3 and read it on port 1
        a_wen = 1'b1; a_waddr = 5'd3; a_wdata = 32'h0000_0003;
        tick();
        a_wen = 1'b0;
        repeat (3) tick();
        dut_a.r_bank[3][0] = ~dut_a.r_bank[3][0];
        a_raddr = {5'd3, 5'd4};
        exp_push(0, 2, 1, 1, 32'd1, "perr_bad");
        exp_push(0, 2, 0, 1, 32'd0, "perr_clean");
        repeat (3) tick();
`endif

        for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
        while (sb.size() != 0) begin
            n_tests = n_tests + 1;
            n_fail  = n_fail + 1;
            $display("FAIL %0s: never checked, expected %h", sb[0].name, sb[0].val);
            sb.delete(0);
        end

        n_tests = n_tests + 1;
        if (a_busy !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL run_busy_direct_a: got %b expected 0", a_busy);
        end
        n_tests = n_tests + 1;
        if (b_busy !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL run_busy_direct_b: got %b expected 0", b_busy);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
